fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the instruction memory. Owns the program counter and drives the memory's read address. Captures the returned word together with its PC into an IF/ID pipeline register, presented to decode over a valid/ready handshake. Handles back-pressure from decode, taken-branch/jump redirects (flush) and out-of-range fetch detection.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned)
- IMEM_BYTES, 65536, instruction memory size in bytes; PCs at or above this are out of range
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  32  read address to instruction memory; equals current PC
- imem_instr  in  32  word returned by instruction memory, combinational, same cycle as imem_addr
- redirect_valid  in  1  one-cycle request to change PC (branch/jump resolved downstream)
- redirect_pc  in  32  redirect target; bits [1:0] ignored
- id_ready  in  1  decode accepts the IF/ID entry this cycle
- id_valid  out  1  IF/ID entry valid
- id_pc  out  32  PC of the presented instruction
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32
- id_instr  out  32  presented instruction word
- id_fault  out  1  presented entry was fetched from PC >= IMEM_BYTES
- fetch_count  out  32  number of entries accepted by decode (valid && ready), wraps

## Operation
- State: pc (32), IF/ID register {valid, pc, pc_plus4, instr, fault}, fetch_count.
- imem_addr = pc at all times, combinational from the register.
- Advance condition `adv` = !id_valid || id_ready (register empty or being consumed).
- Priority per cycle: rst > redirect_valid > adv > hold.
- rst: pc <= RESET_PC; id_valid <= 0; id_pc, id_pc_plus4 <= 0; id_instr <= 32'h0000_0013 (NOP); id_fault <= 0; fetch_count <= 0.
- redirect_valid: pc <= {redirect_pc[31:2], 2'b00}; id_valid <= 0 (flush), regardless of id_ready. The flushed entry does not increment fetch_count, even if id_ready is high that cycle.
- adv (no redirect): id_valid <= 1; id_pc <= pc; id_pc_plus4 <= pc + 4; id_instr <= imem_instr; id_fault <= (pc >= IMEM_BYTES); pc <= pc + 4.
- Hold: all state unchanged. imem_addr stays stable, so the same word is re-read.
- Fault entries carry id_instr = NOP instead of the memory word. Fetch continues; decode owns trap handling.
- fetch_count increments when id_valid && id_ready && !redirect_valid.
- PC arithmetic is 32-bit unsigned, wraps 0xFFFF_FFFC -> 0x0000_0000. The wrap fetch is in range (fault = 0).

## Timing
- Fetch latency is 1 cycle: the word at PC P appears on id_* the cycle after pc = P, provided adv held.
- After rst deasserts at edge E0: imem_addr = RESET_PC during the following cycle; id_valid = 1 with that word after edge E1.
- Redirect sampled at edge N: id_valid = 0 after N; pc = target after N; target word valid after N+1. One bubble per redirect.
- Back-pressure: while id_valid && !id_ready, all id_* outputs and pc are stable. No entry is dropped or duplicated.
- Redirect and id_ready high in the same cycle: redirect wins and the entry is discarded.
- rst asserted mid-stream overrides any pending redirect or stall within the same edge.
- Maximum throughput is one instruction per cycle with id_ready tied high.

## Structure
- Shared package: NOP encoding (32'h0000_0013), default RESET_PC, XLEN = 32, word-align helper constant.
- One sub-module is natural: if_id_reg, the valid/ready pipeline register with flush input. fetch_unit contains the PC logic and the counter.

## Test plan
- Reset, id_ready = 1, memory word i = i: id_pc sequence 0, 4, 8, 12 on consecutive cycles; id_instr 0, 1, 2, 3; fetch_count = 4 after 4 accepts.
- Drop id_ready for 3 cycles at id_pc = 8: outputs hold pc 8, instr 2; resume gives 12 next. No skip or repeat.
- Redirect to 0x0000_0102 while presenting pc 0x10: one bubble (id_valid = 0), then id_pc = 0x100; the 0x10 entry is not counted.
- Redirect asserted with id_ready = 0: entry flushed; id_pc = target after the bubble.
- RESET_PC = 0xFFF8, IMEM_BYTES = 65536: pc 0xFFF8 and 0xFFFC have fault = 0; 0x10000 has fault = 1 and instr = NOP.
- rst asserted during a stall with redirect_valid = 1: next cycle id_valid = 0, pc = RESET_PC, fetch_count = 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: XLEN, NOP encoding,
// default reset PC and word-alignment helpers.
package fetch_unit_pkg;
  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: valid/ready handshake with a flush that
// overrides loading. The upstream side always has a word to offer.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_pc_plus4,
  input  logic [31:0] d_instr,
  input  logic        d_fault,
  output logic        adv,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        fault
);

  assign adv = !valid || ready;

  // Flush only clears valid; the payload is left as-is since nothing reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= NOP;
      fault    <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid    <= 1'b1;
      pc       <= d_pc;
      pc_plus4 <= d_pc_plus4;
      instr    <= d_instr;
      fault    <= d_fault;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address and feeds decode through the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        id_fault,
  output logic [31:0] fetch_count
);

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

  logic [31:0] pc;
  logic [31:0] pc_next4;
  logic        pc_fault;
  logic [31:0] fetch_word;
  logic        adv;

  assign imem_addr  = pc;
  assign pc_next4   = pc + INSTR_BYTES;
  // 33-bit compare so an IMEM_BYTES near 2^32 cannot overflow.
  assign pc_fault   = ({1'b0, pc} >= IMEM_LIMIT);
  assign fetch_word = pc_fault ? NOP : imem_instr;

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .ready      (id_ready),
    .d_pc       (pc),
    .d_pc_plus4 (pc_next4),
    .d_instr    (fetch_word),
    .d_fault    (pc_fault),
    .adv        (adv),
    .valid      (id_valid),
    .pc         (id_pc),
    .pc_plus4   (id_pc_plus4),
    .instr      (id_instr),
    .fault      (id_fault)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & WORD_ALIGN_MASK;
    end else if (adv) begin
      pc <= pc_next4;
    end
  end

  // An entry flushed by a redirect is discarded, never counted as accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (id_valid && id_ready && !redirect_valid) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects,
// out-of-range fetch near the top of memory and reset mid-stall.
module tb_fetch_unit;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_instr, fetch_count;
  logic        id_fault;

  logic [31:0] imem_addr2, imem_instr2;
  logic        id_valid2, id_fault2;
  logic [31:0] id_pc2, id_pc_plus42, id_instr2, fetch_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: word at byte address a holds a/4.
  assign imem_instr  = {2'b00, imem_addr[31:2]};
  assign imem_instr2 = {2'b00, imem_addr2[31:2]};

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_instr(id_instr), .id_fault(id_fault), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'h0000_FFF8), .IMEM_BYTES(65536)) dut_top (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
    .id_valid(id_valid2), .id_pc(id_pc2), .id_pc_plus4(id_pc_plus42),
    .id_instr(id_instr2), .id_fault(id_fault2), .fetch_count(fetch_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] ins, input logic [31:0] cnt);
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, v});
    check({tag, ".pc"}, id_pc, p);
    check({tag, ".instr"}, id_instr, ins);
    check({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    step(); step();
    check("rst.valid", {31'b0, id_valid}, 32'd0);
    check("rst.instr", id_instr, NOP_W);
    check("rst.pc", id_pc, 32'd0);
    check("rst.pc4", id_pc_plus4, 32'd0);
    check("rst.count", fetch_count, 32'd0);
    check("rst.addr", imem_addr, 32'd0);
    check("rst.addr2", imem_addr2, 32'h0000_FFF8);

    rst = 1'b0;
    step();                                         // E1
    chk_entry("e1", 1'b1, 32'd0, 32'd0, 32'd0);
    check("e1.pc4", id_pc_plus4, 32'd4);
    check("e1.addr", imem_addr, 32'd4);
    check("top.e1.pc", id_pc2, 32'h0000_FFF8);
    check("top.e1.fault", {31'b0, id_fault2}, 32'd0);
    check("top.e1.instr", id_instr2, 32'h0000_3FFE);
    step();                                         // E2
    chk_entry("e2", 1'b1, 32'd4, 32'd1, 32'd1);
    check("top.e2.pc", id_pc2, 32'h0000_FFFC);
    check("top.e2.fault", {31'b0, id_fault2}, 32'd0);
    check("top.e2.instr", id_instr2, 32'h0000_3FFF);
    step();                                         // E3
    chk_entry("e3", 1'b1, 32'd8, 32'd2, 32'd2);
    check("top.e3.pc", id_pc2, 32'h0001_0000);
    check("top.e3.fault", {31'b0, id_fault2}, 32'd1);
    check("top.e3.instr", id_instr2, NOP_W);
    check("top.e3.pc4", id_pc_plus42, 32'h0001_0004);
    check("top.e3.count", fetch_count2, 32'd2);

    id_ready = 1'b0;
    step(); chk_entry("stall1", 1'b1, 32'd8, 32'd2, 32'd2);
    step(); chk_entry("stall2", 1'b1, 32'd8, 32'd2, 32'd2);
    step(); chk_entry("stall3", 1'b1, 32'd8, 32'd2, 32'd2);
    check("stall.addr", imem_addr, 32'd12);
    check("stall.pc4", id_pc_plus4, 32'd12);

    id_ready = 1'b1;
    step(); chk_entry("resume", 1'b1, 32'd12, 32'd3, 32'd3);
    step(); chk_entry("e8", 1'b1, 32'h10, 32'd4, 32'd4);

    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    check("redir.valid", {31'b0, id_valid}, 32'd0);
    check("redir.count", fetch_count, 32'd4);
    check("redir.addr", imem_addr, 32'h100);
    redirect_valid = 1'b0;
    step(); chk_entry("redir.t0", 1'b1, 32'h100, 32'h40, 32'd4);
    step(); chk_entry("redir.t1", 1'b1, 32'h104, 32'h41, 32'd5);

    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    check("redir2.valid", {31'b0, id_valid}, 32'd0);
    check("redir2.count", fetch_count, 32'd5);
    check("redir2.addr", imem_addr, 32'h200);
    redirect_valid = 1'b0;
    step(); chk_entry("redir2.t0", 1'b1, 32'h200, 32'h80, 32'd5);
    step(); chk_entry("redir2.hold", 1'b1, 32'h200, 32'h80, 32'd5);

    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    check("rst2.valid", {31'b0, id_valid}, 32'd0);
    check("rst2.addr", imem_addr, 32'd0);
    check("rst2.count", fetch_count, 32'd0);
    check("rst2.instr", id_instr, NOP_W);
    rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    step(); chk_entry("rst2.e1", 1'b1, 32'd0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
